// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-side controller of an async FIFO (pointer, full, fill level, overflow)
module async_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                  src_clk,
    input  logic                  src_rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH:0]   wr_ptr_bin,
    input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  clr_overflow
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;

    typedef enum logic {HOLD, RUN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d, fill_q, fill_d;
    logic            af_q, af_d, ovf_q, ovf_d;
    logic            full;

    // Full uses the raw synchronised read pointer, so it is pessimistic by the CDC latency.
    assign full        = (ptr_q - rd_ptr_sync) == DEPTH;
    assign wr_ready    = (state_q == RUN) && !full;
    assign ram_we      = wr_valid && wr_ready;
    assign ram_waddr   = ptr_q[ADDR_WIDTH-1:0];
    assign wr_ptr_bin  = ptr_q;
    assign fill_level  = fill_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;

    // Next state: hold-off counter, pointer advance, occupancy and sticky overflow (set beats clear).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == HOLD) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = RUN;
        end
        ptr_d  = ptr_q + PW'(ram_we);
        fill_d = ptr_d - rd_ptr_sync;
        af_d   = fill_d >= PW'(AFULL_THRESH);
        ovf_d  = ((state_q == RUN) && wr_valid && !wr_ready) || (ovf_q && !clr_overflow);
    end

    // State registers; reset drops everything to HOLD with an empty pointer.
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            ptr_q   <= '0;
            fill_q  <= '0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
